pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Generic, parametrised pipeline stage register with a valid/ready handshake, flush, and invalid-beat side-effect masking. It replaces the fixed per-stage registers between core stages (e.g. MEMPREP→MEMEX) with one reusable block. An optional skid entry cuts the combinational ready path, so downstream stalls do not ripple combinationally upstream. A saturating stall counter is included for performance analysis.

## Interface
- DATA_W, 64: payload width in bits (packed stage fields: pc4, rd, alu_result, regfile_we, rd_data_sel, …)
- KILL_MASK, '0: DATA_W-bit mask; bits set here are forced to 0 when a beat is stored with in_invalid=1 (e.g. the regfile_we position)
- CNT_W, 16: stall counter width
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held beats and any beat offered this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  block can accept a beat
- in_invalid  in  1  upstream beat is a bubble/killed instruction
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  beat present downstream
- out_ready  in  1  downstream accepts beat
- out_invalid  out  1  invalid flag of the presented beat
- out_data  out  DATA_W  presented payload (masked if invalid)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Accept = in_valid & in_ready; take = out_valid & out_ready.
- On store: data ← in_data & ~KILL_MASK if in_invalid, else in_data; invalid flag stored alongside. Invalid beats still flow (they occupy a slot); only masked bits change.
- States (skid build): EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY: accept → ONE (main ← in).
  - ONE: accept & take → ONE (main ← in); accept & !take → TWO (skid ← in); !accept & take → EMPTY; else hold.
  - TWO: take → ONE (main ← skid); else hold. No accept possible.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- out_valid = (state != EMPTY); out_data/out_invalid always come from main.
- flush: next state EMPTY regardless of accept/take; a beat offered in the flush cycle is dropped; a take in the flush cycle still completes downstream.
- stall_cnt: +1 per cycle with out_valid & !out_ready; saturates at all-ones; cleared only by rst (not by flush).
- rst mid-operation: all held beats are discarded, and a beat offered in a reset cycle is not stored.

## Timing
- Latency: an accept in cycle N gives out_valid in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset values: state EMPTY, out_valid 0, out_data 0, out_invalid 0, in_ready 1, stall_cnt 0.
- Order is strictly FIFO; the skid beat never overtakes main.
- Simultaneous flush & rst: rst dominates (same result).

## Configuration
- PIPE_SKID_EN defined: three-state skid build as above; in_ready registered, with no path from out_ready.
- PIPE_SKID_EN undefined: single entry, states EMPTY/ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - TWO is unreachable; all other behaviour, reset values and the counter are identical.

## Structure
- pipeline_pkg: state enum (PS_EMPTY, PS_ONE, PS_TWO) and a helper function for kill masking.
- Per-stage payload structs (e.g. a memprep_memex_t with pc4, rd, alu_result, regfile_we, rd_data_sel) live in pipeline_pkg and are cast to DATA_W at instantiation.
- One sub-module: pipe_sat_counter (CNT_W, inc, rst → saturating count), reused by other perf counters.

## Test plan
- Reset: after rst held 2 cycles → out_valid 0, out_data 0, in_ready 1, stall_cnt 0; a beat offered during rst never appears.
- Streaming: 8 beats 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, 1-cycle latency.
- Skid (PIPE_SKID_EN): 0xA accepted, out_ready=0, 0xB accepted → in_ready 0 next cycle; release out_ready → 0xA then 0xB, no loss or duplicate; stall_cnt counts the stalled cycles.
- Kill mask: KILL_MASK=0x1, in_data=0xFF, in_invalid=1 → out_data 0xFE, out_invalid 1; with in_invalid=0 → 0xFF.
- Flush: state TWO plus flush while 0xC is offered → next cycle out_valid 0, in_ready 1, and 0xC never emitted; stall_cnt unchanged by flush.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a beat held → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and helpers for the generic pipeline stage register.
//   pipe_state_e    - occupancy state of a stage register (EMPTY / ONE / TWO)
//   memprep_memex_t - example stage payload; cast to DATA_W at instantiation
//   kill_bits()     - clears the kill-masked payload bits of an invalid beat
package pipeline_pkg;

    // Widest payload the helper function handles; callers cast to/from it.
    localparam int PIPE_MAX_W = 256;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    // MEMPREP -> MEMEX payload (56 bits); regfile_we is the usual kill target.
    typedef struct packed {
        logic [15:0] pc4;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic        regfile_we;
        logic [1:0]  rd_data_sel;
    } memprep_memex_t;

    // A killed beat still occupies a slot; only its side-effect bits are cleared.
    function automatic logic [PIPE_MAX_W-1:0] kill_bits(
        input logic [PIPE_MAX_W-1:0] data,
        input logic [PIPE_MAX_W-1:0] mask,
        input logic                  invalid
    );
        return invalid ? (data & ~mask) : data;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter for performance statistics.
//   clk   - clock
//   rst   - synchronous active-high clear
//   inc   - count this cycle
//   count - current value, holds at all-ones
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready stage register with flush, kill masking of
// invalid beats and a saturating stall counter.
// Build option: PIPE_SKID_EN adds a skid entry so in_ready is registered and
// has no combinational path from out_ready; otherwise a single entry with
// in_ready = !out_valid | out_ready.
//   clk, rst                         - clock, synchronous active-high reset
//   flush                            - drop held beats and the beat offered now
//   in_valid/in_ready/in_invalid/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_invalid/out_data - downstream handshake and payload
//   stall_cnt                        - cycles with out_valid & !out_ready
module pipeline_stage_reg
    import pipeline_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter logic [DATA_W-1:0] KILL_MASK = '0,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_invalid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_invalid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state, state_nxt;
    logic [DATA_W-1:0] main_data, in_store;
    logic              main_inv;
    logic              accept, take, load_main;

    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign out_valid = (state != PS_EMPTY);
    assign out_data  = main_data;
    assign out_invalid = main_inv;

    assign in_store = DATA_W'(kill_bits(PIPE_MAX_W'(in_data), PIPE_MAX_W'(KILL_MASK), in_invalid));

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data;
    logic              skid_inv;
    logic              load_skid, main_from_skid;
`endif

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state)
            PS_EMPTY: begin
                if (accept) begin
                    state_nxt = PS_ONE;
                    load_main = 1'b1;
                end
            end
            PS_ONE: begin
                if (accept && take) begin
                    load_main = 1'b1;
                end else if (take) begin
                    state_nxt = PS_EMPTY;
`ifdef PIPE_SKID_EN
                end else if (accept) begin
                    state_nxt = PS_TWO;
                    load_skid = 1'b1;
`endif
                end
            end
`ifdef PIPE_SKID_EN
            PS_TWO: begin
                // skid always drains into main, so FIFO order is preserved
                if (take) begin
                    state_nxt      = PS_ONE;
                    main_from_skid = 1'b1;
                end
            end
`endif
            default: state_nxt = PS_EMPTY;
        endcase
        // flush drops everything, including a beat offered this cycle
        if (flush) begin
            state_nxt = PS_EMPTY;
            load_main = 1'b0;
`ifdef PIPE_SKID_EN
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PS_EMPTY;
            main_data <= '0;
            main_inv  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= in_store;
                main_inv  <= in_invalid;
`ifdef PIPE_SKID_EN
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_inv  <= skid_inv;
`endif
            end
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_data <= '0;
            skid_inv  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (load_skid) begin
                skid_data <= in_store;
                skid_inv  <= in_invalid;
            end
            // registered from next state: no path from out_ready
            in_ready <= (state_nxt != PS_TWO);
        end
    end
`else
    assign in_ready = !out_valid | out_ready;
`endif

    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam logic [DW-1:0] KM = 16'h0001;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_invalid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, out_invalid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [DW:0] sb_q[$];
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_stage_reg #(.DATA_W(DW), .KILL_MASK(KM), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_invalid(in_invalid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_invalid(out_invalid), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on accept, pop/compare on take; stall model alongside.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_stall = 0;
        end else begin
            chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
            if (out_valid && !out_ready && exp_stall != 15) exp_stall++;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0)
                    chk("spurious_beat", 32'(sb_q.size()), 32'd1);
                else
                    chk("beat", 32'({out_invalid, out_data}), 32'(sb_q.pop_front()));
            end
            if (flush)
                sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back({in_invalid, in_invalid ? (in_data & ~KM) : in_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_invalid = 1'b0;
        in_data = 16'h0055; out_ready = 1'b1;
        // reset, with a beat offered that must never appear
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        step();
        chk("rst_no_beat", 32'(out_valid), 32'd0);

        // streaming 1..8, one-cycle latency
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // kill mask
        in_valid = 1'b1; in_data = 16'h00FF; in_invalid = 1'b1;
        step();
        chk("kill_data", 32'(out_data), 32'h00FE);
        chk("kill_inv", 32'(out_invalid), 32'd1);
        in_invalid = 1'b0;
        step();
        chk("nokill_data", 32'(out_data), 32'h00FF);
        chk("nokill_inv", 32'(out_invalid), 32'd0);
        in_valid = 1'b0;
        step();

        // stall with a second beat pending
        in_valid = 1'b1; in_data = 16'h000A; out_ready = 1'b0;
        step();
        in_data = 16'h000B;
        step();
        chk("skid_in_ready", 32'(in_ready), 32'd0);
`ifdef PIPE_SKID_EN
        in_valid = 1'b0;
`endif
        step();
        step();
        chk("skid_stall", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("skid_drain", 32'(sb_q.size()), 32'd0);

        // flush while full and a beat (0xC) is offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000D;
        step();
        in_data = 16'h000E;
        step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_data = 16'h000C; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_stall", 32'(stall_cnt), 32'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_beat", 32'(out_valid), 32'd0);
        end

        // saturation
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000F;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("sat_stall", 32'(stall_cnt), 32'd15);
        chk("sat_held", 32'(out_data), 32'h000F);

        // reset mid-operation with a beat offered
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h0077;
        repeat (2) step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_out_data", 32'(out_data), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_stall", 32'(stall_cnt), 32'd0);
        repeat (2) step();
        chk("rst2_no_beat", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
